// File: rtl/if_fetch_stage_if.sv
// Handshake and bus signals between the instruction-fetch stage and its environment
// (hazard unit, branch/jump resolution, instruction memory, IF/ID consumer).
interface if_fetch_stage_if;
  logic        PCWrite_Disable;
  logic        IF_ID_Write_Disable;
  logic        IF_ID_Flush;
  logic        BranchGate;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] IMem_Data;
  logic        IMem_Ready;
  logic [31:0] IMem_Addr;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [15:0] Stall_Count;
  logic [15:0] Flush_Count;

  modport master (
    output PCWrite_Disable, IF_ID_Write_Disable, IF_ID_Flush,
    output BranchGate, BranchTarget, Jump, JumpTarget,
    output IMem_Data, IMem_Ready,
    input  IMem_Addr, PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
    input  Stall_Count, Flush_Count
  );

  modport slave (
    input  PCWrite_Disable, IF_ID_Write_Disable, IF_ID_Flush,
    input  BranchGate, BranchTarget, Jump, JumpTarget,
    input  IMem_Data, IMem_Ready,
    output IMem_Addr, PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
    output Stall_Count, Flush_Count
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC sequencing with branch/jump redirect, the IF/ID
// pipeline register with stall/flush handling, and saturating stall/flush counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           Clk,
  input logic           Rst,
  if_fetch_stage_if.slave bus
);

  logic [31:0] pc_r;
  logic [31:0] ifid_instr_r;
  logic [31:0] ifid_pc4_r;
  logic        ifid_valid_r;
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  logic        redirect_s;
  logic        squash_s;
  logic        stall_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] pc_nxt_s;
  logic [31:0] instr_nxt_s;
  logic [31:0] pc4_nxt_s;
  logic        valid_nxt_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Next-state selection for PC and IF/ID; reset is applied in the register block.
  always_comb begin
    redirect_s  = bus.BranchGate | bus.Jump;
    squash_s    = redirect_s | bus.IF_ID_Flush;
    stall_s     = ~squash_s & (bus.IF_ID_Write_Disable | ~bus.IMem_Ready);
    target_s    = bus.BranchGate ? {bus.BranchTarget[31:2], 2'b00}
                                 : {bus.JumpTarget[31:2], 2'b00};
    pc_plus4_s  = pc_r + 32'd4;
    pc_nxt_s    = pc_r;
    instr_nxt_s = 32'h0000_0000;
    pc4_nxt_s   = 32'h0000_0000;
    valid_nxt_s = 1'b0;

    if (redirect_s) begin
      pc_nxt_s = target_s;
    end else if (bus.PCWrite_Disable || !bus.IMem_Ready) begin
      pc_nxt_s = pc_r;
    end else begin
      pc_nxt_s = pc_plus4_s;
    end

    // A hold keeps whatever IF/ID has; anything else that is not a load becomes a bubble.
    if (squash_s) begin
      instr_nxt_s = 32'h0000_0000;
      pc4_nxt_s   = 32'h0000_0000;
      valid_nxt_s = 1'b0;
    end else if (bus.IF_ID_Write_Disable) begin
      instr_nxt_s = ifid_instr_r;
      pc4_nxt_s   = ifid_pc4_r;
      valid_nxt_s = ifid_valid_r;
    end else if (bus.IMem_Ready && !bus.PCWrite_Disable) begin
      instr_nxt_s = bus.IMem_Data;
      pc4_nxt_s   = pc_plus4_s;
      valid_nxt_s = 1'b1;
    end else begin
      instr_nxt_s = 32'h0000_0000;
      pc4_nxt_s   = 32'h0000_0000;
      valid_nxt_s = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_r         <= {RESET_PC[31:2], 2'b00};
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
      stall_cnt_r  <= 16'h0000;
      flush_cnt_r  <= 16'h0000;
    end else begin
      pc_r         <= pc_nxt_s;
      ifid_instr_r <= instr_nxt_s;
      ifid_pc4_r   <= pc4_nxt_s;
      ifid_valid_r <= valid_nxt_s;
      stall_cnt_r  <= stall_s  ? sat_inc(stall_cnt_r) : stall_cnt_r;
      flush_cnt_r  <= squash_s ? sat_inc(flush_cnt_r) : flush_cnt_r;
    end
  end

  assign bus.IMem_Addr         = pc_r;
  assign bus.PC                = pc_r;
  assign bus.IF_ID_Instruction = ifid_instr_r;
  assign bus.IF_ID_PCPlus4     = ifid_pc4_r;
  assign bus.IF_ID_Valid       = ifid_valid_r;
  assign bus.Stall_Count       = stall_cnt_r;
  assign bus.Flush_Count       = flush_cnt_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a vector table plus hand-written corner
// sequences, each vector's expectation queued when driven and checked after the edge.
module tb_if_fetch_stage;

  typedef struct {
    logic        rst;
    logic        pcwd;
    logic        idwd;
    logic        flush;
    logic        bg;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        rdy;
    logic [31:0] data;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [15:0] e_stall;
    logic [15:0] e_flush;
  } vec_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t tbl[18];

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(
    input logic rst, input logic pcwd, input logic idwd, input logic flush,
    input logic bg, input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
    input logic rdy, input logic [31:0] data,
    input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_pc4,
    input logic e_valid, input logic [15:0] e_stall, input logic [15:0] e_flush);
    vec_t v;
    v.rst = rst; v.pcwd = pcwd; v.idwd = idwd; v.flush = flush;
    v.bg = bg; v.bt = bt; v.jmp = jmp; v.jt = jt; v.rdy = rdy; v.data = data;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    v.e_stall = e_stall; v.e_flush = e_flush;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Rst                     = v.rst;
    bus.PCWrite_Disable     = v.pcwd;
    bus.IF_ID_Write_Disable = v.idwd;
    bus.IF_ID_Flush         = v.flush;
    bus.BranchGate          = v.bg;
    bus.BranchTarget        = v.bt;
    bus.Jump                = v.jmp;
    bus.JumpTarget          = v.jt;
    bus.IMem_Ready          = v.rdy;
    bus.IMem_Data           = v.data;
  endtask

  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    @(negedge Clk);
    drive(v);
    sb.push_back(v);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"},    bus.PC, e.e_pc);
    chk({tag, ".addr"},  bus.IMem_Addr, e.e_pc);
    chk({tag, ".instr"}, bus.IF_ID_Instruction, e.e_instr);
    chk({tag, ".pc4"},   bus.IF_ID_PCPlus4, e.e_pc4);
    chk({tag, ".valid"}, {31'd0, bus.IF_ID_Valid}, {31'd0, e.e_valid});
    chk({tag, ".stall"}, {16'd0, bus.Stall_Count}, {16'd0, e.e_stall});
    chk({tag, ".flush"}, {16'd0, bus.Flush_Count}, {16'd0, e.e_flush});
  endtask

  localparam logic [31:0] IA = 32'hA000_0001;
  localparam logic [31:0] IB = 32'hB000_0002;
  localparam logic [31:0] IC = 32'hC000_0003;
  localparam logic [31:0] ID = 32'hD000_0004;
  localparam logic [31:0] IE = 32'hE000_0005;
  localparam logic [31:0] IF = 32'hF000_0006;
  localparam logic [31:0] IG = 32'h1000_0007;
  localparam logic [31:0] IH = 32'h2000_0008;
  localparam logic [31:0] IX = 32'hDEAD_BEEF;

  initial begin
    vec_t v;
    // rst pcwd idwd fl  bg bt  jmp jt  rdy data ->  pc  instr pc4  v  stall flush
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IX, 32'h00,32'h0,32'h00,1'b0,16'd0,16'd0);
    tbl[1]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IA, 32'h04,IA,   32'h04,1'b1,16'd0,16'd0);
    tbl[2]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IB, 32'h08,IB,   32'h08,1'b1,16'd0,16'd0);
    tbl[3]  = mk(1'b0,1'b1,1'b1,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IC, 32'h08,IB,   32'h08,1'b1,16'd1,16'd0);
    tbl[4]  = mk(1'b0,1'b1,1'b1,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IC, 32'h08,IB,   32'h08,1'b1,16'd2,16'd0);
    tbl[5]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IC, 32'h0C,IC,   32'h0C,1'b1,16'd2,16'd0);
    tbl[6]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,ID, 32'h10,ID,   32'h10,1'b1,16'd2,16'd0);
    tbl[7]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b0,IX, 32'h10,32'h0,32'h00,1'b0,16'd3,16'd0);
    tbl[8]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b0,IX, 32'h10,32'h0,32'h00,1'b0,16'd4,16'd0);
    tbl[9]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b0,IX, 32'h10,32'h0,32'h00,1'b0,16'd5,16'd0);
    tbl[10] = mk(1'b0,1'b0,1'b1,1'b0, 1'b1,32'h40,  1'b1,32'h80,  1'b1,IX, 32'h40,32'h0,32'h00,1'b0,16'd5,16'd1);
    tbl[11] = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b1,32'h83,  1'b1,IX, 32'h80,32'h0,32'h00,1'b0,16'd5,16'd2);
    tbl[12] = mk(1'b0,1'b0,1'b1,1'b1, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IE, 32'h84,32'h0,32'h00,1'b0,16'd5,16'd3);
    tbl[13] = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IF, 32'h88,IF,   32'h88,1'b1,16'd5,16'd3);
    tbl[14] = mk(1'b0,1'b0,1'b1,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IG, 32'h8C,IF,   32'h88,1'b1,16'd6,16'd3);
    tbl[15] = mk(1'b0,1'b1,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IG, 32'h8C,32'h0,32'h00,1'b0,16'd6,16'd3);
    tbl[16] = mk(1'b1,1'b1,1'b1,1'b0, 1'b1,32'h100, 1'b0,32'h0,   1'b0,IX, 32'h00,32'h0,32'h00,1'b0,16'd0,16'd0);
    tbl[17] = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,   1'b1,IH, 32'h04,IH,   32'h04,1'b1,16'd0,16'd0);

    for (int i = 0; i < 18; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // PC wraparound and masked redirect targets
    apply("wrap_jmp", mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b1,32'hFFFF_FFFF, 1'b1,IX,
                         32'hFFFF_FFFC,32'h0,32'h0,1'b0,16'd0,16'd1));
    apply("wrap_inc", mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b1,IA,
                         32'h0000_0000,IA,32'h0000_0000,1'b1,16'd0,16'd1));
    apply("br_mask",  mk(1'b0,1'b0,1'b0,1'b0, 1'b1,32'h23, 1'b0,32'h0, 1'b1,IX,
                         32'h20,32'h0,32'h0,1'b0,16'd0,16'd2));

    // Stall counter saturation
    apply("sat_rst",  mk(1'b1,1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,IX,
                         32'h0,32'h0,32'h0,1'b0,16'd0,16'd0));
    v = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,IX,
           32'h0,32'h0,32'h0,1'b0,16'd0,16'd0);
    @(negedge Clk);
    drive(v);
    repeat (65533) @(posedge Clk);
    apply("sat_fffe", mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,IX,
                         32'h0,32'h0,32'h0,1'b0,16'hFFFE,16'd0));
    for (int k = 0; k < 3; k++) begin
      apply($sformatf("sat_ffff%0d", k), mk(1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,IX,
                         32'h0,32'h0,32'h0,1'b0,16'hFFFF,16'd0));
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PCWrite_Disable  input  1  hazard stall: hold PC.
REQ-005 SHALL have port IF_ID_Write_Disable  input  1  hazard stall: hold IF/ID register.
REQ-006 SHALL have port IF_ID_Flush  input  1  squash IF/ID contents.
REQ-007 SHALL have port BranchGate  input  1  taken branch, redirect to BranchTarget.
REQ-008 SHALL have port BranchTarget  input  32  branch destination.
REQ-009 SHALL have port Jump  input  1  jump, redirect to JumpTarget.
REQ-010 SHALL have port JumpTarget  input  32  jump destination.
REQ-011 SHALL have port IMem_Data  input  32  instruction word at IMem_Addr.
REQ-012 SHALL have port IMem_Ready  input  1  IMem_Data valid this cycle.
REQ-013 SHALL have port IMem_Addr  output  32  fetch address, equals PC combinationally.
REQ-014 SHALL have port PC  output  32  current program counter.
REQ-015 SHALL have port IF_ID_Instruction  output  32  registered instruction.
REQ-016 SHALL have port IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-017 SHALL have port IF_ID_Valid  output  1  IF/ID holds a real instruction.
REQ-018 SHALL have port Stall_Count  output  16  stall-cycle counter.
REQ-019 SHALL have port Flush_Count  output  16  flush-cycle counter.

Function
REQ-020 Redirect SHALL be defined as BranchGate OR Jump; when both are 1, BranchTarget SHALL win.
REQ-021 Next PC priority SHALL be: Rst -> RESET_PC; redirect -> target; PCWrite_Disable -> hold; IMem_Ready=0 -> hold; else PC+4.
REQ-022 Redirect SHALL update PC regardless of PCWrite_Disable and IMem_Ready; the in-flight fetch SHALL be discarded.
REQ-023 PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000); PC[1:0] SHALL always be 2'b00, targets' low two bits ignored.
REQ-024 IF/ID update priority SHALL be: Rst -> bubble; IF_ID_Flush or redirect -> bubble; IF_ID_Write_Disable -> hold all three fields; IMem_Ready=1 and PCWrite_Disable=0 -> load {IMem_Data, PC+4, Valid=1}; else bubble.
REQ-025 A bubble SHALL be IF_ID_Instruction=32'h0000_0000 (NOP), IF_ID_PCPlus4=32'h0, IF_ID_Valid=0.
REQ-026 Fetch-to-IF/ID latency SHALL be one cycle: data accepted at edge N appears on IF/ID outputs after edge N.
REQ-027 Flush SHALL take priority over IF_ID_Write_Disable in the same cycle.
REQ-028 Stall_Count SHALL increment by 1 on each edge where no flush/redirect applies and (IF_ID_Write_Disable=1 or IMem_Ready=0); SHALL saturate at 16'hFFFF.
REQ-029 Flush_Count SHALL increment by 1 on each edge where IF_ID_Flush=1 or redirect=1; SHALL saturate at 16'hFFFF.
REQ-030 No instruction SHALL be loaded twice nor skipped across any stall sequence.

Reset
REQ-031 On Rst=1 at an edge: PC=RESET_PC, IF/ID=bubble, Stall_Count=0, Flush_Count=0, overriding all other inputs.
REQ-032 Rst asserted mid-stall or mid-redirect SHALL discard the pending event; first fetch after Rst deasserts SHALL be RESET_PC.

Verification
REQ-033 Reset then IMem_Ready=1 for 3 cycles, IMem_Data=A,B,C -> PC 0,4,8,12; IF_ID_Instruction A,B,C with PCPlus4 4,8,12, Valid=1.
REQ-034 PC=8, PCWrite_Disable=IF_ID_Write_Disable=1 for 2 cycles -> PC stays 8, IF/ID holds, Stall_Count +2; release -> instruction at 8 loaded exactly once.
REQ-035 BranchGate=1, Jump=1, BranchTarget=0x40, JumpTarget=0x80, IF_ID_Write_Disable=1 -> next PC=0x40, IF/ID bubble, Flush_Count +1.
REQ-036 IMem_Ready=0 for 3 cycles at PC=0x10 -> PC holds 0x10, IF/ID bubble each cycle, Stall_Count +3.
REQ-037 PC=32'hFFFF_FFFC, IMem_Ready=1 -> PC wraps to 0, IF_ID_PCPlus4=0; BranchTarget=0x23 -> PC=0x20.
REQ-038 Stall_Count preloaded to 16'hFFFE by 65534 stall cycles, 3 more stalls -> Stall_Count=16'hFFFF, no wrap.
